// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmit line between NUM_REQ byte requesters. A
//   round-robin arbiter picks one requester while the line is idle. The
//   chosen byte is sent as one frame: a start bit (0), DATA_BITS data bits
//   LSB first, and a stop bit (1). Every bit lasts OVERSAMPLE tick pulses.
//
// Handshake (valid/ready):
//   A requester holds req_valid[i] high with its byte on its req_data slice.
//   req_ready is a one-hot combinational grant. It is only non-zero in IDLE
//   and only while rst_n is high. A byte is consumed on the rising edge where
//   req_valid[i] and req_ready[i] are both high. The byte is copied into the
//   shift register on that edge. After that edge the requester may change or
//   drop its data. Dropping req_valid before that edge consumes nothing.
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   rst_n      synchronous active-low reset
//   tick       one-clk oversample strobe from the baud-rate generator
//   req_valid  per-requester byte-available flags
//   req_data   packed bytes; requester i at [i*DATA_BITS +: DATA_BITS]
//   req_ready  one-hot accept strobe
//   tx         registered serial output, idle high
//   busy       high while a frame is in progress
//   grant_id   index of the requester most recently accepted
//   state_dbg  current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
module uart_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [GW-1:0]                grant_id,
  output logic [1:0]                   state_dbg
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        ptr_q, ptr_d;

  logic                 sel_found;
  logic [GW-1:0]        sel_idx;
  logic [GW-1:0]        arb_idx;

  // Round-robin search. It starts at ptr and wraps modulo NUM_REQ.
  // The first valid index found wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = GW'((int'(ptr_q) + k) % NUM_REQ);
      if (!sel_found && req_valid[arb_idx]) begin
        sel_found = 1'b1;
        sel_idx   = arb_idx;
      end
    end
  end

  // The grant is gated by rst_n. This keeps req_ready at zero during reset,
  // so no requester can see a ready that will not be honoured.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == ST_IDLE) && sel_found) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;

    if (state_q == ST_IDLE) begin
      // Ticks are ignored here. The counters are cleared on accept, so a
      // tick on the accept edge does not count toward the start bit.
      tx_d = 1'b1;
      if (sel_found) begin
        shift_d    = req_data[sel_idx*DATA_BITS +: DATA_BITS];
        grant_d    = sel_idx;
        ptr_d      = GW'((int'(sel_idx) + 1) % NUM_REQ);
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        state_d    = ST_START;
        tx_d       = 1'b0;
      end
    end else if (tick) begin
      if (tick_cnt_q == TICK_LAST) begin
        // End of the current bit period.
        tick_cnt_d = '0;
        case (state_q)
          ST_START: begin
            state_d = ST_DATA;
            tx_d    = shift_q[0];
          end
          ST_DATA: begin
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shift_d   = shift_q >> 1;
              tx_d      = shift_d[0];
            end
          end
          ST_STOP: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        endcase
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      grant_q    <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_q;
  assign state_dbg = state_q;

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing the single serial line.
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame.
REQ-003 Parameter OVERSAMPLE, default 16, tick pulses per serial bit period.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 tick  input  1  one-clk-wide oversample strobe from the baud-rate generator.
REQ-007 req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-008 req_data  input  NUM_REQ*DATA_BITS  packed bytes; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-009 req_ready  output  NUM_REQ  one-hot grant/accept strobe.
REQ-010 tx  output  1  serial line; idle high.
REQ-011 busy  output  1  high while a frame is in progress.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the requester most recently accepted.

Function
REQ-013 The FSM shall have exactly four states: IDLE, START, DATA and STOP.
REQ-014 IDLE arbitration: round-robin; the search starts at ptr and wraps modulo NUM_REQ; the first index with req_valid set is selected.
REQ-015 In IDLE, req_ready shall be driven combinationally as the one-hot of the selected index, all zeros if no req_valid bit is set, and all zeros in every non-IDLE state.
REQ-016 Accept occurs when req_valid[i] and req_ready[i] are both high on the same edge; on accept, the block shall do all of the following:
- latch req_data slice i into the shift register;
- set grant_id to i;
- set ptr to (i+1) mod NUM_REQ;
- clear the tick counter and bit counter;
- go to START.
REQ-017 Changes to req_data after the accept edge shall not affect the frame in progress.
REQ-018 A requester deasserting req_valid before accept shall have no effect, and no byte shall be consumed from it.
REQ-019 The tick counter shall advance only on clk edges where tick is high; clk edges without tick shall hold all timing state.
REQ-020 Each bit shall last exactly OVERSAMPLE tick pulses; the state or bit advances on the edge where tick is high and the tick counter equals OVERSAMPLE-1, and the tick counter then returns to 0.
REQ-021 START shall drive tx=0 for one bit period and then go to DATA.
REQ-022 DATA shall drive tx from the shift register LSB first for DATA_BITS bit periods, then go to STOP.
REQ-023 STOP shall drive tx=1 for one bit period and then go to IDLE.
REQ-024 tx shall be registered: tx=1 in IDLE, and tx changes only on state or bit advance edges.
REQ-025 busy shall be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-026 The earliest next accept shall occur one clk after re-entering IDLE, i.e. one idle clk between back-to-back frames.
REQ-027 A tick arriving on the accept edge shall not count toward the start bit.
REQ-028 Ticks received while in IDLE shall be ignored.
REQ-029 Frame length shall be (DATA_BITS+2)*OVERSAMPLE tick pulses; with the defaults this is 160 ticks.
REQ-030 Width rule: the tick counter shall be clog2(OVERSAMPLE) bits, the bit counter clog2(DATA_BITS) bits, and ptr clog2(NUM_REQ) bits.
REQ-031 Counters shall never exceed their terminal values (OVERSAMPLE-1 and DATA_BITS-1).

Reset
REQ-032 When rst_n=0 at a rising edge, the following shall hold from the next cycle:
- state=IDLE, tx=1, busy=0, req_ready=0, grant_id=0, ptr=0;
- tick counter, bit counter and shift register all 0.
REQ-033 Reset mid-frame shall abandon the frame, force tx=1 on the next edge, and leave the byte unretransmitted.
REQ-034 While rst_n=0, req_ready shall be all zeros regardless of req_valid.

Verification
REQ-035 Single request: req_valid=4'b0100, req_data slice2=8'hA5 -> grant_id=2; tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 ticks; busy high for exactly 160 ticks.
REQ-036 Fairness: all four req_valid held high continuously -> accepts in order 0,1,2,3,0, with one accept per frame and one idle clk between frames.
REQ-037 tick tied high -> start bit low for exactly 16 clks after the accept edge; full frame lasts 160 clks.
REQ-038 tick held low after accept -> tx stays 0 and busy stays 1 indefinitely, with no state advance.
REQ-039 Reset in DATA at bit 3 -> next edge: tx=1, busy=0, grant_id=0, ptr=0; the subsequent request from requester 1 starts a fresh frame.
REQ-040 req_data changed mid-frame, and a tick coincident with the accept edge -> transmitted byte equals the value latched at accept, and the start bit still lasts 16 ticks.
